// File: rtl/iicmb_wb_sequencer.sv
// Wishbone master that runs one complete single-byte I2C transaction on the IICMB core
// (Set Bus, Start, address, data write/read, Stop) for each client request.
module iicmb_wb_sequencer #(
   parameter int WB_ADDR_WIDTH = 2,
   parameter int WB_DATA_WIDTH = 8,
   parameter int IRQ_TIMEOUT   = 4096
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic                     req_rw_i,
   input  logic [7:0]               req_bus_i,
   input  logic [6:0]               req_addr_i,
   input  logic [7:0]               req_wdata_i,
   output logic                     rsp_valid_o,
   output logic [2:0]               rsp_status_o,
   output logic [7:0]               rsp_rdata_o,
   output logic                     busy_o,
   output logic                     cyc_o,
   output logic                     stb_o,
   output logic                     we_o,
   output logic [WB_ADDR_WIDTH-1:0] adr_o,
   output logic [WB_DATA_WIDTH-1:0] dat_o,
   input  logic [WB_DATA_WIDTH-1:0] dat_i,
   input  logic                     ack_i,
   input  logic                     irq_i
);

   localparam int TW = $clog2(IRQ_TIMEOUT + 1);

   localparam logic [WB_ADDR_WIDTH-1:0] ADR_CSR  = WB_ADDR_WIDTH'(0);
   localparam logic [WB_ADDR_WIDTH-1:0] ADR_DPR  = WB_ADDR_WIDTH'(1);
   localparam logic [WB_ADDR_WIDTH-1:0] ADR_CMDR = WB_ADDR_WIDTH'(2);

   localparam logic [2:0] STS_OK      = 3'd0;
   localparam logic [2:0] STS_NAK     = 3'd1;
   localparam logic [2:0] STS_AL      = 3'd2;
   localparam logic [2:0] STS_ERR     = 3'd3;
   localparam logic [2:0] STS_TIMEOUT = 3'd4;

   typedef enum logic [2:0] {ST_INIT, ST_IDLE, ST_ISSUE, ST_ACCESS, ST_WAIT, ST_RESP} state_t;
   typedef enum logic [2:0] {PH_INIT, PH_BUS, PH_START, PH_ADDR, PH_DATA, PH_STOP} phase_t;
   typedef enum logic [2:0] {ACC_CSR_WR, ACC_DPR_WR, ACC_CMD_WR, ACC_CMD_RD, ACC_DPR_RD} acc_t;

   state_t                   state_q, state_d;
   phase_t                   phase_q, phase_d;
   acc_t                     acc_q, acc_d;
   logic [TW-1:0]            timer_q, timer_d;
   logic                     cyc_d, stb_d, we_d;
   logic [WB_ADDR_WIDTH-1:0] adr_d;
   logic [WB_DATA_WIDTH-1:0] dat_d;
   logic                     ready_d, busy_d, rsp_valid_d;
   logic [2:0]               status_d;
   logic [7:0]               rdata_d;
   logic                     rw_q;
   logic [7:0]               bus_q, wdata_q;
   logic [6:0]               addr_q;
   logic                     accept;
   logic                     acc_we;
   logic [WB_ADDR_WIDTH-1:0] acc_adr;
   logic [7:0]               acc_byte;

   assign accept = (state_q == ST_IDLE) && req_valid_i && req_ready_o;

   // Register address and payload of the access selected by the current phase and access kind.
   always_comb begin
      acc_we   = 1'b1;
      acc_adr  = ADR_CMDR;
      acc_byte = 8'h00;
      unique case (acc_q)
         ACC_CSR_WR: begin
            acc_adr  = ADR_CSR;
            acc_byte = 8'hC0;
         end
         ACC_DPR_WR: begin
            acc_adr = ADR_DPR;
            case (phase_q)
               PH_BUS:  acc_byte = bus_q;
               PH_ADDR: acc_byte = {addr_q, rw_q};
               default: acc_byte = wdata_q;
            endcase
         end
         ACC_CMD_WR: begin
            case (phase_q)
               PH_BUS:   acc_byte = 8'h06;
               PH_START: acc_byte = 8'h04;
               PH_ADDR:  acc_byte = 8'h01;
               PH_DATA:  acc_byte = rw_q ? 8'h03 : 8'h01;
               default:  acc_byte = 8'h05;
            endcase
         end
         ACC_CMD_RD: acc_we = 1'b0;
         ACC_DPR_RD: begin
            acc_we  = 1'b0;
            acc_adr = ADR_DPR;
         end
         default: acc_we = 1'b1;
      endcase
   end

   // Sequencer: every access is followed by an idle bus cycle (ST_ISSUE), CMDR writes by an irq wait.
   always_comb begin
      state_d  = state_q;
      phase_d  = phase_q;
      acc_d    = acc_q;
      timer_d  = timer_q;
      cyc_d    = 1'b0;
      stb_d    = 1'b0;
      we_d     = 1'b0;
      adr_d    = '0;
      dat_d    = '0;
      busy_d   = busy_o;
      status_d = rsp_status_o;
      rdata_d  = rsp_rdata_o;
      unique case (state_q)
         ST_INIT: begin
            phase_d = PH_INIT;
            acc_d   = ACC_CSR_WR;
            state_d = ST_ISSUE;
         end
         ST_IDLE: begin
            if (accept) begin
               busy_d   = 1'b1;
               status_d = STS_OK;
               rdata_d  = 8'h00;
               phase_d  = PH_BUS;
               acc_d    = ACC_DPR_WR;
               state_d  = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = acc_we;
            adr_d   = acc_adr;
            dat_d   = WB_DATA_WIDTH'(acc_byte);
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (ack_i && stb_o) begin
               state_d = ST_ISSUE;
               unique case (acc_q)
                  ACC_CSR_WR: state_d = ST_IDLE;
                  ACC_DPR_WR: acc_d = ACC_CMD_WR;
                  ACC_CMD_WR: begin
                     state_d = ST_WAIT;
                     timer_d = '0;
                  end
                  ACC_DPR_RD: begin
                     rdata_d = dat_i[7:0];
                     phase_d = PH_STOP;
                     acc_d   = ACC_CMD_WR;
                  end
                  ACC_CMD_RD: begin
                     // Status priority AL > ERR > NAK > DON; a NAK still gets a Stop unless it came from Stop.
                     if (dat_i[5]) begin
                        status_d = STS_AL;
                        state_d  = ST_RESP;
                     end else if (dat_i[4]) begin
                        status_d = STS_ERR;
                        state_d  = ST_RESP;
                     end else if (dat_i[6]) begin
                        status_d = STS_NAK;
                        if (phase_q == PH_STOP) begin
                           state_d = ST_RESP;
                        end else begin
                           phase_d = PH_STOP;
                           acc_d   = ACC_CMD_WR;
                        end
                     end else if (dat_i[7]) begin
                        case (phase_q)
                           PH_BUS: begin
                              phase_d = PH_START;
                              acc_d   = ACC_CMD_WR;
                           end
                           PH_START: begin
                              phase_d = PH_ADDR;
                              acc_d   = ACC_DPR_WR;
                           end
                           PH_ADDR: begin
                              phase_d = PH_DATA;
                              acc_d   = rw_q ? ACC_CMD_WR : ACC_DPR_WR;
                           end
                           PH_DATA: begin
                              if (rw_q) begin
                                 acc_d = ACC_DPR_RD;
                              end else begin
                                 phase_d = PH_STOP;
                                 acc_d   = ACC_CMD_WR;
                              end
                           end
                           default: state_d = ST_RESP;
                        endcase
                     end else begin
                        status_d = STS_ERR;
                        state_d  = ST_RESP;
                     end
                  end
                  default: state_d = ST_INIT;
               endcase
            end else begin
               cyc_d = cyc_o;
               stb_d = stb_o;
               we_d  = we_o;
               adr_d = adr_o;
               dat_d = dat_o;
            end
         end
         ST_WAIT: begin
            if (irq_i) begin
               acc_d   = ACC_CMD_RD;
               state_d = ST_ISSUE;
            end else if (timer_q == TW'(IRQ_TIMEOUT - 1)) begin
               status_d = STS_TIMEOUT;
               state_d  = ST_RESP;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_RESP: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_INIT;
      endcase
      ready_d     = (state_d == ST_IDLE);
      rsp_valid_d = (state_d == ST_RESP);
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q      <= ST_INIT;
         phase_q      <= PH_INIT;
         acc_q        <= ACC_CSR_WR;
         timer_q      <= '0;
         cyc_o        <= 1'b0;
         stb_o        <= 1'b0;
         we_o         <= 1'b0;
         adr_o        <= '0;
         dat_o        <= '0;
         req_ready_o  <= 1'b0;
         busy_o       <= 1'b0;
         rsp_valid_o  <= 1'b0;
         rsp_status_o <= 3'd0;
         rsp_rdata_o  <= 8'h00;
         rw_q         <= 1'b0;
         bus_q        <= 8'h00;
         addr_q       <= 7'h00;
         wdata_q      <= 8'h00;
      end else begin
         state_q      <= state_d;
         phase_q      <= phase_d;
         acc_q        <= acc_d;
         timer_q      <= timer_d;
         cyc_o        <= cyc_d;
         stb_o        <= stb_d;
         we_o         <= we_d;
         adr_o        <= adr_d;
         dat_o        <= dat_d;
         req_ready_o  <= ready_d;
         busy_o       <= busy_d;
         rsp_valid_o  <= rsp_valid_d;
         rsp_status_o <= status_d;
         rsp_rdata_o  <= rdata_d;
         if (accept) begin
            rw_q    <= req_rw_i;
            bus_q   <= req_bus_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
         end
      end
   end

endmodule

// File: doc/iicmb_wb_sequencer.md
Name: iicmb_wb_sequencer

Overview:
Wishbone master that drives the IICMB core's register file (CSR 0x0, DPR 0x1, CMDR 0x2) to perform complete single-byte I2C transactions. It turns one request into the full command sequence, waiting on irq between steps:
- Set Bus
- Start
- address byte
- data write or read
- Stop
Sits between a simple valid/ready client port and the DUT's Wishbone slave port. It replaces hand-written register sequencing in the test flow.

Parameters:
WB_ADDR_WIDTH, 2, Wishbone address width
WB_DATA_WIDTH, 8, Wishbone data width
IRQ_TIMEOUT, 4096, max clk_i cycles waited for irq per command before abort

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  reset, asynchronous, active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  sequencer can accept request
req_rw_i  in  1  0=write byte, 1=read byte
req_bus_i  in  8  I2C bus ID
req_addr_i  in  7  I2C slave address
req_wdata_i  in  8  byte to write
rsp_valid_o  out  1  one-cycle response pulse
rsp_status_o  out  3  000 OK, 001 NAK, 010 ARB_LOST, 011 ERR, 100 TIMEOUT
rsp_rdata_o  out  8  byte read (valid with rsp_valid_o when req_rw=1 and status OK)
busy_o  out  1  transaction in progress
cyc_o  out  1  WB cycle
stb_o  out  1  WB strobe
we_o  out  1  WB write enable
adr_o  out  WB_ADDR_WIDTH  WB register address
dat_o  out  WB_DATA_WIDTH  WB write data
dat_i  in  WB_DATA_WIDTH  WB read data
ack_i  in  1  WB acknowledge
irq_i  in  1  IICMB interrupt

Behaviour:
Reset values:
- All outputs 0 except req_ready_o=0.
- FSM goes to INIT.

Wishbone access:
- Each access asserts cyc_o, stb_o, we_o, adr_o and dat_o together, held stable until ack_i is sampled 1.
- All deasserted the cycle after ack; at least one idle cycle between accesses.
- Read data captured from dat_i in the ack cycle.
- Outputs are registered.

States:
- INIT: write CSR=0xC0 (enable + interrupt enable), then IDLE.
- IDLE: req_ready_o=1, busy_o=0. On req_valid_i&req_ready_o, latch all req_* fields, set busy_o, then go to the command sequence.
- Command sequence, one micro-op at a time:
  1. DPR<=bus; CMDR<=0x06; WAIT.
  2. CMDR<=0x04; WAIT.
  3. DPR<={addr,rw}; CMDR<=0x01; WAIT.
  4. If rw=0: DPR<=wdata; CMDR<=0x01; WAIT. If rw=1: CMDR<=0x03 (read with NAK); WAIT; then read DPR into rdata.
  5. CMDR<=0x05; WAIT.
  6. RESP.
- WAIT: count cycles until irq_i=1, then read CMDR (this clears irq) and decode it:
  - bit7 DON → continue.
  - bit6 NAK → status 001.
  - bit5 AL → status 010.
  - bit4 ERR → status 011.
  - Priority when several bits are set: AL > ERR > NAK > DON.
- Counter reaching IRQ_TIMEOUT without irq → status 100.
- Failure handling:
  - NAK during address or data phase: skip remaining data ops, still issue Stop, then report NAK.
  - AL, ERR or TIMEOUT: no Stop; go to RESP directly.
- RESP: rsp_valid_o=1 for exactly one cycle with status and rdata; next cycle IDLE.
- req_ready_o=0 from acceptance until the cycle after RESP. Requests presented while busy are not accepted.
- An irq_i already high at WAIT entry counts immediately.
- An irq_i asserted during a Wishbone access is not consumed until WAIT.
- Reset mid-transaction: WB signals drop immediately (async), no response issued, FSM restarts at INIT.
- ack_i without stb_o is ignored.

Test Plan:
1. Reset release → single WB write adr=0 dat=0xC0, then req_ready_o=1 within 3 cycles of its ack.
2. Write req bus=0x05 addr=0x22 wdata=0x78, slave ACKs:
   - WB sequence: DPR 05, CMDR 06, rd CMDR, CMDR 04, rd CMDR, DPR 44, CMDR 01, rd CMDR, DPR 78, CMDR 01, rd CMDR, CMDR 05, rd CMDR.
   - Response: rsp_status=000.
3. Read req bus=0 addr=0x22, slave returns 0xA5:
   - WB sequence: DPR 45, CMDR 03, rd DPR.
   - Response: rsp_rdata=0xA5, status 000.
4. No slave at addr 0x10 → CMDR reads 0xC0 after address write; Stop still issued; rsp_status=001; the data byte is never written to DPR.
5. irq_i held 0 after Start with IRQ_TIMEOUT=16 → rsp_status=100 at 16 cycles after WAIT entry; no Stop written; req_ready_o returns 1.
6. rst_i asserted low mid data write → cyc_o/stb_o drop the same cycle, no rsp_valid_o; after release, INIT CSR=0xC0 write repeats.
